// File: rtl/fir_out_sink.sv
// fir_out_sink: round/saturate FIR results into a show-ahead FIFO with sat/drop counters; ports clk, rst, fir_valid/fir_data in, dout_valid/dout_ready/dout out, level, sat_cnt, drop_cnt, cnt_clr
module fir_out_sink #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 12,
  parameter int SHIFT = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  input  logic [IN_W-1:0]  fir_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [OUT_W-1:0] dout,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             cnt_clr
);
  localparam int RW = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  logic [IN_W:0] sum;
  logic [RW-1:0] r1_q, r1_d;
  logic v1_q, v1_d, v2_q, v2_d, sat2_q, sat2_d, sat;
  logic [OUT_W-1:0] d2_q, d2_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
  logic push, pop, drop;
  always_comb begin
    sum = {1'b0, fir_data} + HALF;
    r1_d = fir_valid ? sum[IN_W:SHIFT] : r1_q;
    v1_d = fir_valid;
    // RW'() of the all-ones max is harmless when RW <= OUT_W: r can never exceed it then
    sat = r1_q > RW'({OUT_W{1'b1}});
    d2_d = sat ? {OUT_W{1'b1}} : OUT_W'(r1_q);
    sat2_d = sat;
    v2_d = v1_q;
    pop = dout_valid & dout_ready;
    // a full FIFO still takes the write when the head leaves in the same cycle
    push = v2_q & ((level_q != LW'(DEPTH)) | pop);
    drop = v2_q & ~push;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    sat_cnt_d = cnt_clr ? '0 : (v2_q & sat2_q & ~&sat_cnt_q) ? sat_cnt_q + CNT_W'(1) : sat_cnt_q;
    drop_cnt_d = cnt_clr ? '0 : (drop & ~&drop_cnt_q) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q <= '0;
      v1_q <= 1'b0;
      d2_q <= '0;
      sat2_q <= 1'b0;
      v2_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      sat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      r1_q <= r1_d;
      v1_q <= v1_d;
      d2_q <= d2_d;
      sat2_q <= sat2_d;
      v2_q <= v2_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      sat_cnt_q <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= d2_q;
    end
  end
  assign dout_valid = level_q != '0;
  assign dout = mem_q[rd_q];
  assign level = level_q;
  assign sat_cnt = sat_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_fir_out_sink.sv
// tb_fir_out_sink: directed scoreboard bench for fir_out_sink
module tb_fir_out_sink;
  logic clk = 1'b0, rst = 1'b1, fir_valid = 1'b0, dout_ready = 1'b0, cnt_clr = 1'b0;
  logic [28:0] fir_data = '0;
  logic dout_valid;
  logic [11:0] dout;
  logic [3:0] level;
  logic [15:0] sat_cnt, drop_cnt;
  int vectors = 0, miscompares = 0;
  int q[$];

  fir_out_sink dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_data(fir_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .level(level), .sat_cnt(sat_cnt), .drop_cnt(drop_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input longint x);
    longint r;
    r = (x + 1024) >> 11;
    return (r > 4095) ? 4095 : int'(r);
  endfunction

  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (q.size() == 0) chk("unexpected_pop", dout, 64'hdead);
      else chk("dout", dout, q.pop_front());
    end
  end

  task automatic send_timed(input logic [28:0] x);
    q.push_back(model(x));
    fir_valid = 1'b1;
    fir_data = x;
    tick();
    fir_valid = 1'b0;
    chk("lat_c1", dout_valid, 0);
    tick();
    chk("lat_c2", dout_valid, 0);
    tick();
    chk("lat_c3", dout_valid, 1);
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int i = 0; i < 30 && level != 0; i++) tick();
    chk("drain_level", level, 0);
    chk("drain_valid", dout_valid, 0);
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_level", level, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();
    dout_ready = 1'b1;
    send_timed(29'd1023);
    tick();
    send_timed(29'd1024);
    tick();
    send_timed(29'd204800);
    tick();
    chk("sat_zero", sat_cnt, 0);
    send_timed(29'd8591310);
    chk("sat_one", sat_cnt, 1);
    tick();
    send_timed(29'h1fffffff);
    chk("sat_two", sat_cnt, 2);
    tick();
    dout_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      fir_valid = 1'b1;
      fir_data = 29'(2048 * k);
      if (k <= 8) q.push_back(k);
      tick();
    end
    fir_valid = 1'b0;
    tick(); tick(); tick();
    chk("full_level", level, 8);
    chk("full_drop", drop_cnt, 2);
    drain();
    dout_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      fir_valid = 1'b1;
      fir_data = 29'(2048 * k);
      q.push_back(k);
      tick();
    end
    fir_valid = 1'b0;
    tick(); tick(); tick();
    chk("hold_level", level, 8);
    fir_valid = 1'b1;
    fir_data = 29'(2048 * 20);
    q.push_back(20);
    tick();
    fir_valid = 1'b0;
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("swap_level", level, 8);
    chk("swap_drop", drop_cnt, 2);
    drain();
    dout_ready = 1'b0;
    for (int i = 0; i < 65550; i++) begin
      fir_valid = 1'b1;
      fir_data = (i < 8) ? 29'(2048 * (i + 1)) : 29'd0;
      if (i < 8) q.push_back(i + 1);
      tick();
    end
    fir_valid = 1'b0;
    tick(); tick(); tick();
    chk("drop_max", drop_cnt, 65535);
    fir_valid = 1'b1;
    fir_data = '0;
    tick(); tick(); tick();
    fir_valid = 1'b0;
    tick(); tick(); tick();
    chk("drop_hold", drop_cnt, 65535);
    chk("level_full", level, 8);
    fir_valid = 1'b1;
    tick();
    fir_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_drop", drop_cnt, 0);
    chk("clr_sat", sat_cnt, 0);
    drain();
    dout_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      fir_valid = 1'b1;
      fir_data = 29'h1fffffff;
      tick();
    end
    fir_valid = 1'b0;
    chk("pre_rst_level", level, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_sat", sat_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    tick(); tick(); tick();
    chk("post_rst_level", level, 0);
    chk("post_rst_sat", sat_cnt, 0);
    dout_ready = 1'b1;
    send_timed(29'd204800);
    tick();
    chk("final_queue", q.size(), 0);
    chk("final_level", level, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_out_sink.md
# fir_out_sink

Output-side companion to the 16-tap parallel symmetric FIR. It consumes the FIR's 29-bit unsigned result stream, which is a valid pulse plus data with no backpressure. Each result is rounded and scaled down to sample width, then saturated. Results go into a small show-ahead FIFO that drains through a valid/ready handshake to the downstream consumer (DAC formatter, capture logic). The block also counts saturation and drop events for software visibility.

## Interface
- IN_W, 29: width of FIR result input.
- OUT_W, 12: width of output sample. Unsigned, same width as the FIR input samples.
- SHIFT, 11: right-shift applied with round-half-up. Must satisfy 1 ≤ SHIFT < IN_W.
- DEPTH, 8: FIFO depth in entries. Must be a power of 2, ≥ 2.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- fir_valid  in  1  one-cycle qualifier for fir_data. No backpressure is possible upstream.
- fir_data  in  IN_W  unsigned FIR result.
- dout_valid  out  1  FIFO non-empty; dout holds the head entry.
- dout_ready  in  1  consumer accepts the head entry when dout_valid && dout_ready.
- dout  out  OUT_W  head sample.
- level  out  clog2(DEPTH)+1  current FIFO occupancy, range 0..DEPTH.
- sat_cnt  out  CNT_W  number of samples clipped to the maximum value. Saturates at all-ones.
- drop_cnt  out  CNT_W  number of samples lost because the FIFO was full. Saturates at all-ones.
- cnt_clr  in  1  synchronous clear of sat_cnt and drop_cnt.

## Operation
- Stage 1 (round), registered, enabled by fir_valid:
  - r = (fir_data + 2^(SHIFT-1)) >> SHIFT.
  - The add is computed at IN_W+1 bits, so no wrap at the input maximum.
  - The s1 valid flag is fir_valid delayed by one cycle.
- Stage 2 (saturate), registered:
  - If r > 2^OUT_W − 1, output 2^OUT_W − 1 and set a sat flag. Otherwise output r[OUT_W-1:0].
  - The s2 valid flag is the s1 valid flag delayed by one cycle.
- Pipeline stages advance every cycle unconditionally. Back-to-back fir_valid every cycle is supported.
- FIFO write is attempted when s2 is valid. The write is accepted if level < DEPTH, or if level == DEPTH and a pop happens in the same cycle.
  - A rejected write discards the sample and increments drop_cnt.
  - The sample's sat flag still increments sat_cnt whether or not the write is accepted.
- FIFO pop occurs on dout_valid && dout_ready. dout_ready while empty is ignored.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in level.
  - Simultaneous push and pop leave level unchanged.
- Counters: cnt_clr has priority over an increment in the same cycle, and the counter reads 0 next cycle. Both counters hold at all-ones rather than wrapping.
- Reset values: dout_valid=0, dout=0, level=0, sat_cnt=0, drop_cnt=0. Pipeline valid flags and data registers clear to 0; pointers clear to 0.
- Reset asserted mid-stream flushes the pipeline and FIFO. In-flight samples are lost and not counted.

## Timing
- Latency: fir_valid high in cycle 0 → s1 valid in cycle 1 → s2 valid in cycle 2 → written on the cycle-2 edge → dout_valid=1 in cycle 3 if the FIFO was empty.
- dout is valid in the same cycle dout_valid rises. dout updates the cycle after each pop, to the next entry.
- level reflects pushes and pops one cycle after the edge on which they occur.
- Counter increments are visible one cycle after the s2-valid cycle of the triggering sample.
- Sustained throughput is 1 sample/cycle when dout_ready is held high.

## Test plan
- Rounding, default parameters, dout_ready=1:
  - fir_data 1023 → dout 0.
  - fir_data 1024 → dout 1.
  - fir_data 204800 → dout 100.
  - Each appears exactly 3 cycles after its fir_valid. sat_cnt stays 0.
- Saturation:
  - fir_data 8591310 (4095×2098, the full-scale FIR output) → dout 4095, sat_cnt=1.
  - fir_data 2^29−1 → dout 4095, sat_cnt=2. No arithmetic wrap.
- Full and drop, dout_ready=0:
  - 10 back-to-back samples with values 2048×k, k=1..10 → level stops at 8, drop_cnt=2.
  - Then raise dout_ready → dout sequence 1..8 in order, level returns to 0, dout_valid falls.
- Full plus simultaneous pop: hold level=8, then in one cycle present an s2-valid sample and assert dout_ready → write accepted, level stays 8, drop_cnt unchanged.
- Counter control:
  - Force drop_cnt to 65535 → further drops leave it at 65535.
  - cnt_clr in the same cycle as a drop → drop_cnt reads 0 next cycle.
- Reset mid-stream: assert rst with 5 entries queued and 2 samples in the pipeline → dout_valid, level, and counters all 0 immediately. After release, the first new sample emerges 3 cycles after its fir_valid.
